// File: rtl/alu_seq_param.sv
// alu_seq_param: parametrised handshaked ALU with flag ports.
// DIV/MOD use an iterative restoring divider; output stage holds under backpressure.
module alu_seq_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         ALU_SEL,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [2*WIDTH-1:0] RESULT,
    output logic               FLAG_C,
    output logic               FLAG_Z,
    output logic               FLAG_N,
    output logic               FLAG_E
);

    localparam int RW = 2 * WIDTH;

    typedef enum logic {
        S_IDLE,
        S_DIV
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mod_q;

    logic             accept;
    logic             is_div;
    logic             div_start;
    logic             div_last;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_try;
    logic [WIDTH:0]   rem_nxt;
    logic             q_bit;
    logic [WIDTH-1:0] quo_nxt;

    logic [RW-1:0]    a_x;
    logic [RW-1:0]    b_x;
    logic [WIDTH:0]   sum_ab;
    logic [WIDTH:0]   sum_aa;
    logic             b_gt_a;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] neg_a;

    logic [RW-1:0]    res_c;
    logic             c_c;
    logic             n_c;
    logic             e_c;

    logic             ld;
    logic [RW-1:0]    ld_res;
    logic             ld_c;
    logic             ld_n;
    logic             ld_e;

    assign IN_READY  = (state == S_IDLE) && (!OUT_VALID || OUT_READY);
    assign accept    = IN_VALID && IN_READY;
    assign is_div    = (ALU_SEL == 4'd3) || (ALU_SEL == 4'd4);
    assign div_start = accept && is_div && (B != '0);
    assign div_last  = (state == S_DIV) && (cnt_q == CNT_W'(1));

    // One restoring step: shift in next dividend bit, keep the
    // subtraction only when it does not borrow.
    assign rem_sh  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign rem_try = rem_sh - {1'b0, dvs_q};
    assign q_bit   = rem_q[WIDTH] | ~rem_try[WIDTH];
    assign rem_nxt = q_bit ? rem_try : rem_sh;
    assign quo_nxt = {dvd_q[WIDTH-2:0], q_bit};

    assign a_x    = {{WIDTH{1'b0}}, A};
    assign b_x    = {{WIDTH{1'b0}}, B};
    assign sum_ab = {1'b0, A} + {1'b0, B};
    assign sum_aa = {1'b0, A} + {1'b0, A};
    assign b_gt_a = (B > A);
    assign diff   = b_gt_a ? (B - A) : (A - B);
    assign neg_a  = ~A + WIDTH'(1);

    // Single-cycle operations and divide-by-zero results
    always_comb begin
        res_c = '0;
        c_c   = 1'b0;
        n_c   = 1'b0;
        e_c   = 1'b0;
        unique case (ALU_SEL)
            4'd0: begin
                res_c = {{(WIDTH-1){1'b0}}, sum_ab};
                c_c   = sum_ab[WIDTH];
            end
            4'd1: begin
                res_c = {{WIDTH{1'b0}}, diff};
                c_c   = b_gt_a;
                n_c   = b_gt_a;
            end
            4'd2: res_c = a_x * b_x;
            4'd3, 4'd4: begin
                res_c = '1;
                e_c   = 1'b1;
            end
            4'd5: res_c = a_x & b_x;
            4'd6: res_c = a_x | b_x;
            4'd7: res_c = a_x ^ b_x;
            4'd8: res_c = {{WIDTH{1'b0}}, ~A};
            4'd9: begin
                res_c = {{WIDTH{1'b0}}, A[WIDTH-2:0], 1'b0};
                c_c   = A[WIDTH-1];
            end
            4'd10: begin
                res_c = a_x >> 1;
                c_c   = A[0];
            end
            4'd11: res_c[2:0] = {A == B, A < B, A > B};
            4'd12: res_c = {{WIDTH{1'b0}}, neg_a};
            4'd13: res_c = {B, A};
            4'd14: res_c = {A, B};
            4'd15: begin
                res_c = {{(WIDTH-1){1'b0}}, sum_aa};
                c_c   = sum_aa[WIDTH];
            end
        endcase
    end

    // Select what the output stage loads this cycle, if anything
    always_comb begin
        ld     = 1'b0;
        ld_res = res_c;
        ld_c   = c_c;
        ld_n   = n_c;
        ld_e   = e_c;
        if (div_last) begin
            ld     = 1'b1;
            ld_res = mod_q ? {{WIDTH{1'b0}}, rem_nxt[WIDTH-1:0]}
                           : {{WIDTH{1'b0}}, quo_nxt};
            ld_c   = 1'b0;
            ld_n   = 1'b0;
            ld_e   = 1'b0;
        end else if (accept && !div_start) begin
            ld = 1'b1;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: busy in DIV until the last quotient bit lands
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (div_start) state_nxt = S_DIV;
            S_DIV:  if (div_last)  state_nxt = S_IDLE;
        endcase
    end

    // Divider registers; operands captured at accept
    always_ff @(posedge CLK) begin
        if (RST) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            mod_q <= 1'b0;
        end else if (div_start) begin
            dvd_q <= A;
            dvs_q <= B;
            rem_q <= '0;
            cnt_q <= CNT_W'(WIDTH);
            mod_q <= (ALU_SEL == 4'd4);
        end else if (state == S_DIV) begin
            dvd_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Output stage: load on result, clear on drain, hold otherwise
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            RESULT    <= '0;
            FLAG_C    <= 1'b0;
            FLAG_Z    <= 1'b0;
            FLAG_N    <= 1'b0;
            FLAG_E    <= 1'b0;
        end else if (ld) begin
            OUT_VALID <= 1'b1;
            RESULT    <= ld_res;
            FLAG_C    <= ld_c;
            FLAG_Z    <= (ld_res == '0);
            FLAG_N    <= ld_n;
            FLAG_E    <= ld_e;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Parametrised, handshaked successor to the team's fixed 8-bit ALU.
- Operand width is set by WIDTH.
- Uses valid/ready flow control on both input and output, with a registered output stage that holds under backpressure.
- DIV/MOD run on an iterative restoring divider (one quotient bit per cycle) instead of a combinational divide.
- Status flags (carry, zero, negative, error) are exported as separate ports.
- Sits between an operand source (sequencer/testbench driver) and a result consumer.

Parameters:
- WIDTH, 8, operand width in bits (>=4). RESULT is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the divider iteration counter (derived; do not override).

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- IN_VALID  input  1  operands/op valid
- IN_READY  output  1  block can accept operands
- A  input  WIDTH  operand A (unsigned)
- B  input  WIDTH  operand B (unsigned)
- ALU_SEL  input  4  operation select
- OUT_VALID  output  1  RESULT/flags valid
- OUT_READY  input  1  consumer accepts result
- RESULT  output  2*WIDTH  result
- FLAG_C  output  1  carry / borrow / shifted-out bit
- FLAG_Z  output  1  RESULT == 0
- FLAG_N  output  1  SUB result negative (B>A)
- FLAG_E  output  1  divide/modulo by zero

Behaviour:
- Reset: state=IDLE; OUT_VALID, RESULT, all flags = 0; divider registers and counter = 0; IN_READY=1 the cycle after RST deasserts.
- Reset asserted mid-division aborts the operation; no result is emitted.
- Accept: an operation is taken on a rising edge where IN_VALID && IN_READY.
- IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY).
  - A result can be drained and a new op accepted in the same cycle.
- Output hold: while OUT_VALID && !OUT_READY, RESULT and flags are held stable. OUT_VALID clears on the handshake edge unless a new result loads on that same edge.
- States:
  - IDLE: accepts operations.
  - DIV: entered from IDLE on accepting ALU_SEL 3/4 with B!=0; runs WIDTH iterations; returns to IDLE on the edge that writes the result.
- Latency:
  - Non-DIV ops and divide-by-zero: RESULT loads on the accept edge; OUT_VALID is high the next cycle.
  - DIV/MOD (B!=0): RESULT loads on the WIDTH-th edge after the accept edge. IN_READY=0 throughout.
- Width rules: A and B are zero-extended to 2*WIDTH bits; results are zero-extended unless stated otherwise.
- Op encoding (0-15 all defined; there is no invalid code):
  - 0 ADD: RESULT=A+B; C=sum bit WIDTH.
  - 1 SUB: RESULT=|A-B| in the low WIDTH bits; N=C=(B>A).
  - 2 MUL: RESULT=A*B (full 2*WIDTH bits); C=0.
  - 3 DIV: quotient. 4 MOD: remainder. For both, B==0 gives RESULT=all-ones and E=1.
  - 5 AND, 6 OR, 7 XOR: bitwise A op B.
  - 8 NOT: ~A (WIDTH bits).
  - 9 SHL: RESULT=(A<<1) truncated to WIDTH; C=A[WIDTH-1].
  - 10 SHR: RESULT=A>>1; C=A[0].
  - 11 CMP: one-hot in RESULT[2:0]: bit0 A>B, bit1 A<B, bit2 A==B.
  - 12 NEG: RESULT=(~A+1) truncated to WIDTH.
  - 13 CAT_BA: {B,A}. 14 CAT_AB: {A,B}.
  - 15 DBL: RESULT=A+A; C=sum bit WIDTH.
- Flags not listed for an op are 0. FLAG_Z is evaluated on the final RESULT for every op.
- Divider: restoring, MSB-first, one quotient bit per cycle. Remainder register is WIDTH+1 bits. Counter counts WIDTH down to 0. Operands are captured at accept, so later changes on A/B do not disturb an in-flight division.

Test Plan:
- WIDTH=8, ADD A=200 B=100 -> RESULT=0x012C, C=1, Z=0, OUT_VALID the cycle after accept.
- WIDTH=8, SUB A=5 B=9 -> RESULT=4, N=1, C=1. Then SUB A=9 B=9 -> RESULT=0, Z=1, N=0.
- WIDTH=8, DIV A=200 B=7 -> RESULT=28 on the 8th edge after accept, IN_READY=0 for those 8 cycles. MOD same operands -> 4. DIV B=0 -> RESULT=0xFFFF, E=1, 1-cycle latency.
- Backpressure: hold OUT_READY=0 and issue ADD 1+2 then XOR -> IN_READY drops, RESULT=3 stays stable. Raise OUT_READY -> XOR accepted on the same edge the first result drains.
- Assert RST at divider iteration 3 of DIV 255/3 -> next cycle OUT_VALID=0, RESULT=0, IN_READY=1, and no stale result is ever emitted.
- WIDTH=16, MUL 0xFFFF*0xFFFF -> RESULT=0xFFFE0001. SHL A=0x8001 -> RESULT=0x0002, C=1. CMP A=3 B=3 -> RESULT=0x4.
